mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the single-cycle CPU's data-memory bus, in parallel with the data memory. It decodes a small register window from the CPU's data address and buffers bytes stored by the CPU in a FIFO. It serializes them 8N1 on `txd` and returns status on loads, so programs under simulation or on board can print without stalling the CPU.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/mmio_uart_tx_if.sv | 17 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/mmio_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: FSM state encoding, register offsets (decoded from addr[3:2]),
// and the bit positions used in the STATUS and CTRL registers.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  // Register offsets, expressed as word index addr[3:2]
  localparam logic [1:0] RegTxdata = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;

  // STATUS bit positions
  localparam int unsigned StatusFullBit  = 0;
  localparam int unsigned StatusEmptyBit = 1;
  localparam int unsigned StatusBusyBit  = 2;
  localparam int unsigned StatusOvfBit   = 3;
  localparam int unsigned StatusCountLsb = 8;

  // CTRL bit positions
  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlIrqEnBit = 1;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus as seen by the UART register window.
//   addr : data address from the CPU
//   din  : store data from the CPU
//   DMWr : store strobe
//   sel  : address falls inside the UART window
//   dout : combinational read data
// master = CPU side, slave = UART side.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic        DMWr;
  logic        sel;
  logic [31:0] dout;

  modport master (output addr, output din, output DMWr, input sel, input dout);
  modport slave  (input addr, input din, input DMWr, output sel, output dout);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (accepted when not full, or when full with a pop)
//   pop      : remove head entry (ignored when empty)
//   rdata    : head entry (valid when not empty)
//   full, empty, count : occupancy, count is log2(Depth)+1 bits
// Depth must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push on full is still taken
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory bus.
// Ports:
//   clk, rst : CPU clock, synchronous active-high reset
//   bus      : mmio_uart_tx_if.slave (addr, din, DMWr in; sel, dout out)
//   txd      : registered serial output, idle high
//   irq      : registered level interrupt (tied 0 unless UART_TX_IRQ_EN)
// Register window at BASE_ADDR: 0x0 TXDATA, 0x4 STATUS, 0x8 CTRL, 0xC reserved.
// Optional feature macro: UART_TX_IRQ_EN (irq output and CTRL bit1).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  mmio_uart_tx_if.slave      bus,
  output logic               txd,
  output logic               irq
);

  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DivLoad = 16'(CLK_DIV - 1);

  logic            hit, wr_txdata, wr_status, wr_ctrl;
  logic [1:0]      reg_sel;
  logic            fifo_full, fifo_empty, pop, busy;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            en_q, ovf_q, irq_en_q;
  uart_state_e     state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            unused_bits;

  assign hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = bus.addr[3:2];
  assign wr_txdata = hit & bus.DMWr & (reg_sel == RegTxdata);
  assign wr_status = hit & bus.DMWr & (reg_sel == RegStatus);
  assign wr_ctrl   = hit & bus.DMWr & (reg_sel == RegCtrl);
  assign bus.sel   = hit;
  assign busy      = (state_q != StIdle);
  assign pop       = (state_q == StIdle) & en_q & ~fifo_empty;
  assign txd       = txd_q;
  assign unused_bits = ^{bus.din[31:8], bus.addr[1:0]};

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .wdata (bus.din[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_ctrl) en_q <= bus.din[CtrlEnBit];
      // Dropped push only when no pop frees a slot this cycle
      if (wr_txdata & fifo_full & ~pop) begin
        ovf_q <= 1'b1;
      end else if (wr_status & bus.din[StatusOvfBit]) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= bus.din[CtrlIrqEnBit];
      irq_q <= irq_en_q & fifo_empty & ~busy;
    end
  end

  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Each level holds for CLK_DIV cycles: counter reloads on every level change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (pop) begin
          state_d = StStart;
          cnt_d   = DivLoad;
          shift_d = fifo_rdata;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          state_d = StData;
          cnt_d   = DivLoad;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d = DivLoad;
          if (idx_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.dout = '0;
    if (hit) begin
      unique case (reg_sel)
        RegStatus: begin
          bus.dout[StatusFullBit]          = fifo_full;
          bus.dout[StatusEmptyBit]         = fifo_empty;
          bus.dout[StatusBusyBit]          = busy;
          bus.dout[StatusOvfBit]           = ovf_q;
          bus.dout[StatusCountLsb +: 8]    = 8'(fifo_count);
        end
        RegCtrl: begin
          bus.dout[CtrlEnBit]    = en_q;
          bus.dout[CtrlIrqEnBit] = irq_en_q;
        end
        default: bus.dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
// A frame-level reference model (byte queue + frame timer) predicts txd,
// irq and register reads every cycle; directed scenarios run first, then
// randomized bus traffic.
module tb_mmio_uart_tx;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Depth  = 4;
  localparam logic [31:0] Base   = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst;
  logic txd, irq;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR  (Base),
    .CLK_DIV    (ClkDiv),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_en, m_irq_en, m_ovf, m_irq;
  int         busy_left, elapsed;
  logic [7:0] cur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Expected serial level from frame position: start, 8 data LSB first, stop
  function automatic logic exp_txd();
    int slot;
    if (busy_left == 0) return 1'b1;
    slot = elapsed / ClkDiv;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return cur[slot-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      2'd1: v = {16'd0, 8'(q.size()), 4'd0, m_ovf, (busy_left != 0),
                 (q.size() == 0), (q.size() == Depth)};
      2'd2: v = {30'd0, m_irq_en, m_en};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void model_edge(input logic r, input logic [31:0] a,
                                     input logic [31:0] d, input logic w);
    logic hit, full, pop, irq_nx;
    if (r) begin
      q.delete();
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_irq = 0;
      busy_left = 0; elapsed = 0;
      return;
    end
    hit    = (a[31:4] == Base[31:4]);
    full   = (q.size() == Depth);
    pop    = (busy_left == 0) && m_en && (q.size() != 0);
    irq_nx = m_irq_en && (q.size() == 0) && (busy_left == 0);
    if (busy_left > 0) begin
      busy_left--;
      elapsed++;
    end
    if (pop) begin
      cur = q.pop_front();
      busy_left = 10 * ClkDiv;
      elapsed = 0;
    end
    if (hit && w) begin
      case (a[3:2])
        2'd0: if (!full || pop) q.push_back(d[7:0]); else m_ovf = 1;
        2'd1: if (d[3]) m_ovf = 0;
        2'd2: begin
          m_en = d[0];
`ifdef UART_TX_IRQ_EN
          m_irq_en = d[1];
`endif
        end
        default: ;
      endcase
    end
`ifdef UART_TX_IRQ_EN
    m_irq = irq_nx;
`else
    m_irq = irq_nx & 1'b0;
`endif
  endfunction

  // One clock of bus activity, with model update and post-edge checks
  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d,
                           input logic w, input logic r);
    rst = r; bus.addr = a; bus.din = d; bus.DMWr = w;
    #1;
    check_eq("sel", {31'd0, bus.sel}, {31'd0, (a[31:4] == Base[31:4])});
    if (!w && !r && (a[31:4] == Base[31:4]))
      check_eq("read", bus.dout, model_read(a[3:2]));
    model_edge(r, a, d, w);
    @(posedge clk);
    #1;
    check_eq("txd", {31'd0, txd}, {31'd0, exp_txd()});
    check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    bus_cycle(Base + {28'd0, off}, d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(Base + 32'h4, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_status(input string tag, input logic [31:0] exp);
    rst = 1'b0; bus.DMWr = 1'b0; bus.addr = Base + 32'h4;
    #1;
    check_eq(tag, bus.dout, exp);
  endtask

  initial begin
    int r;
    logic [31:0] v;
    m_en = 0; m_irq_en = 0; m_ovf = 0; m_irq = 0;
    busy_left = 0; elapsed = 0; cur = '0;
    rst = 1'b1; bus.addr = '0; bus.din = '0; bus.DMWr = 1'b0;

    repeat (3) bus_cycle(Base + 32'h4, 32'd0, 1'b0, 1'b1);
    expect_status("reset_status", 32'h0000_0002);
    check_eq("reset_txd", {31'd0, txd}, 32'd1);
    check_eq("reset_irq", {31'd0, irq}, 32'd0);

    // Single 0x55 frame: start bit two edges after the store
    wr(4'h8, 32'd1);
    wr(4'h0, 32'h55);
    check_eq("pre_start_txd", {31'd0, txd}, 32'd1);
    idle(1);
    check_eq("start_bit", {31'd0, txd}, 32'd0);
    idle(44);

    // Overflow with enable off
    wr(4'h8, 32'd0);
    for (int i = 0; i < 5; i++) wr(4'h0, 32'(i + 16));
    expect_status("ovf_status", 32'h0000_0409);
    wr(4'h4, 32'h8);
    expect_status("ovf_clear", 32'h0000_0401);

    // Three queued bytes sent back to back
    bus_cycle(Base + 32'h4, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) wr(4'h0, $urandom);
    wr(4'h8, 32'd1);
    idle(3 * 41 + 5);
    expect_status("b2b_done", 32'h0000_0002);

    // Reset in the middle of a frame
    wr(4'h0, $urandom);
    wr(4'h0, $urandom);
    idle(16);
    bus_cycle(Base + 32'h4, 32'd0, 1'b0, 1'b1);
    check_eq("rst_mid_txd", {31'd0, txd}, 32'd1);
    expect_status("rst_mid_status", 32'h0000_0002);
    idle(50);

`ifdef UART_TX_IRQ_EN
    wr(4'h8, 32'h3);
    check_eq("irq_on", {31'd0, irq}, 32'd1);
    wr(4'h0, 32'hA5);
    idle(50);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        wr(4'h0, $urandom);
      end else if (r < 19) begin
        v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                        : {30'd0, 1'($urandom_range(0, 1)), 1'b1};
        wr(4'h8, v);
      end else if (r < 22) begin
        wr(4'h4, $urandom);
      end else if (r < 24) begin
        wr(4'hC, $urandom);
      end else if (r < 28) begin
        bus_cycle($urandom & 32'h0FFF_FFFC, $urandom, 1'b1, 1'b0);
      end else if (r == 99 && $urandom_range(0, 4) == 0) begin
        bus_cycle(Base + 32'h4, 32'd0, 1'b0, 1'b1);
      end else begin
        bus_cycle(Base + {28'd0, 2'($urandom_range(0, 3)), 2'b00}, $urandom, 1'b0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
